// File: rtl/reg32_write_arbiter_pkg.sv
// Shared types and constants for the reg32 write arbiter.
// Holds the arbiter state encoding, the default parameters and the last_grant reset value.
package reg32_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_LOCK_MAX = 16;

  // Resetting the pointer to the top ID hands first priority to requester 0.
  localparam int LAST_GRANT_RST = DEF_NUM_REQ - 1;

  function automatic int last_grant_rst(input int num_req);
    return num_req - 1;
  endfunction

endpackage

// File: rtl/reg32_write_arbiter_if.sv
// Requester-side bus of the reg32 write arbiter.
// Carries the write handshake in one direction and the stored-value status in the other.
interface reg32_write_arbiter_if
  import reg32_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           q;
  logic [IDW-1:0]        q_owner;
  logic                  q_valid;
  logic                  busy;
  logic                  lock_abort;

  modport master (
    output req_valid, req_data, req_lock,
    input  req_ready, q, q_owner, q_valid, busy, lock_abort
  );

  modport slave (
    input  req_valid, req_data, req_lock,
    output req_ready, q, q_owner, q_valid, busy, lock_abort
  );

endinterface

// File: rtl/reg32.sv
// Plain 32-bit storage register with load enable.
// Shared by all requesters through the write arbiter.
module reg32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Picks the first masked request strictly after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     id
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx] && mask[idx]) begin
        grant[idx] = 1'b1;
        id         = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg32_write_arbiter.sv
// Round-robin write arbiter in front of a shared reg32, with burst lock and lock watchdog.
// state      | meaning
// ARB_IDLE   | round-robin among all valid requesters
// ARB_LOCKED | only the owner may write; watchdog counts cycles without an owner write
module reg32_write_arbiter
  import reg32_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int LOCK_MAX = DEF_LOCK_MAX,
  parameter int IDW      = $clog2(NUM_REQ)
) (
  input logic                 clk,
  input logic                 rst_n,
  reg32_write_arbiter_if.slave bus
);

  localparam int             CW     = $clog2(LOCK_MAX + 1);
  localparam logic [IDW-1:0] LG_RST = IDW'(last_grant_rst(NUM_REQ));
  localparam logic [CW-1:0]  WD_END = CW'(LOCK_MAX - 1);

  arb_state_t         state;
  logic [IDW-1:0]     owner;
  logic [IDW-1:0]     last_grant;
  logic [CW-1:0]      wd_cnt;
  logic               busy_r;
  logic               abort_r;
  logic [IDW-1:0]     owner_q;
  logic               q_valid_r;

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     win_id;
  logic               xfer;
  logic               win_lock;
  logic [31:0]        win_data;

  // In LOCKED the mask leaves only the owner, so the picker can only ever return it.
  always_comb begin
    mask = '1;
    if (state == ARB_LOCKED) begin
      mask = '0;
      mask[owner] = 1'b1;
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .mask  (mask),
    .ptr   (last_grant),
    .grant (grant),
    .id    (win_id)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_data = bus.req_data[i*32 +: 32];
      end
    end
  end

  assign xfer     = |(grant & bus.req_valid);
  assign win_lock = |(grant & bus.req_lock);

  reg32 u_reg32 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (xfer),
    .d     (win_data),
    .q     (bus.q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      last_grant <= LG_RST;
      wd_cnt     <= '0;
      busy_r     <= 1'b0;
      abort_r    <= 1'b0;
      owner_q    <= '0;
      q_valid_r  <= 1'b0;
    end else begin
      abort_r <= 1'b0;
      if (xfer) begin
        owner_q    <= win_id;
        q_valid_r  <= 1'b1;
        last_grant <= win_id;
      end
      case (state)
        ARB_IDLE: begin
          if (xfer && win_lock) begin
            state  <= ARB_LOCKED;
            owner  <= win_id;
            wd_cnt <= '0;
            busy_r <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          // An owner write on the expiry edge wins over the watchdog.
          if (xfer) begin
            wd_cnt <= '0;
            if (!win_lock) begin
              state  <= ARB_IDLE;
              busy_r <= 1'b0;
            end
          end else if (wd_cnt == WD_END) begin
            state   <= ARB_IDLE;
            wd_cnt  <= '0;
            busy_r  <= 1'b0;
            abort_r <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ARB_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.q_owner    = owner_q;
  assign bus.q_valid    = q_valid_r;
  assign bus.busy       = busy_r;
  assign bus.lock_abort = abort_r;

endmodule

// File: tb/tb_reg32_write_arbiter.sv
// Self-checking bench for reg32_write_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_reg32_write_arbiter;
  import reg32_arb_pkg::*;

  localparam int N  = 4;
  localparam int LM = 16;

  logic clk;
  logic rst_n;

  logic [N-1:0] tv_valid;
  logic [N-1:0] tv_lock;
  logic [31:0]  tv_data [N];

  int total = 0;
  int bad   = 0;

  reg32_write_arbiter_if #(.NUM_REQ(N)) bus ();

  assign bus.req_valid = tv_valid;
  assign bus.req_lock  = tv_lock;
  assign bus.req_data  = {tv_data[3], tv_data[2], tv_data[1], tv_data[0]};

  reg32_write_arbiter #(
    .NUM_REQ  (N),
    .LOCK_MAX (LM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit          m_locked;
  int          m_own;
  int          m_last;
  int          m_cnt;
  logic [31:0] m_q;
  int          m_qown;
  bit          m_qv;
  bit          m_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_locked = 0;
    m_own    = 0;
    m_last   = N - 1;
    m_cnt    = 0;
    m_q      = '0;
    m_qown   = 0;
    m_qv     = 0;
    m_abort  = 0;
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_locked) begin
      if (tv_valid[m_own]) r[m_own] = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (tv_valid[i]) begin
          r[i] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic m_edge(input logic [N-1:0] r);
    int w;
    w = -1;
    for (int j = 0; j < N; j++) if (r[j]) w = j;
    m_abort = 0;
    if (w >= 0) begin
      m_q    = tv_data[w];
      m_qown = w;
      m_qv   = 1;
      m_last = w;
      if (m_locked) begin
        m_cnt    = 0;
        m_locked = tv_lock[w];
      end else if (tv_lock[w]) begin
        m_locked = 1;
        m_own    = w;
        m_cnt    = 0;
      end
    end else if (m_locked) begin
      m_cnt++;
      if (m_cnt == LM) begin
        m_locked = 0;
        m_cnt    = 0;
        m_abort  = 1;
      end
    end
  endtask

  // Called in the low phase with inputs already applied; returns in the next low phase.
  task automatic step();
    logic [N-1:0] er;
    #1;
    er = exp_ready();
    chk("ready", 32'(bus.req_ready), 32'(er));
    chk("onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
    @(posedge clk);
    m_edge(er);
    #1;
    chk("q", bus.q, m_q);
    chk("q_owner", 32'(bus.q_owner), 32'(m_qown));
    chk("q_valid", 32'(bus.q_valid), 32'(m_qv));
    chk("busy", 32'(bus.busy), 32'(m_locked));
    chk("lock_abort", 32'(bus.lock_abort), 32'(m_abort));
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l);
    tv_valid = v;
    tv_lock  = l;
  endtask

  int          aborts;
  logic [31:0] q_hold;
  int          rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n    = 1'b0;
    tv_valid = '0;
    tv_lock  = '0;
    for (int i = 0; i < N; i++) tv_data[i] = 32'h1111_1111 * (i + 1);
    m_reset();

    #12 rst_n = 1'b1;
    #1;
    chk("rst_q", bus.q, 32'h0);
    chk("rst_q_valid", 32'(bus.q_valid), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);

    // round-robin fairness
    drive(4'b1111, 4'b0000);
    for (int s = 0; s < 5; s++) begin
      step();
      chk("rr_owner", 32'(bus.q_owner), 32'(rr_exp[s]));
      chk("rr_q", bus.q, 32'h1111_1111 * (rr_exp[s] + 1));
    end

    // lock burst by requester 2 while 0 and 1 stay valid
    drive(4'b0010, 4'b0000);
    step();
    tv_data[2] = 32'hA5A5_A5A5;
    drive(4'b0111, 4'b0100);
    step();
    chk("burst_busy1", 32'(bus.busy), 32'd1);
    tv_data[2] = 32'h5A5A_5A5A;
    step();
    tv_data[2] = 32'hFFFF_FFFF;
    drive(4'b0111, 4'b0000);
    step();
    chk("burst_end_q", bus.q, 32'hFFFF_FFFF);
    chk("burst_end_busy", 32'(bus.busy), 32'd0);
    drive(4'b1011, 4'b0000);
    step();
    chk("after_burst_owner", 32'(bus.q_owner), 32'd3);

    // watchdog: requester 1 locks then drops valid
    drive(4'b0010, 4'b0010);
    step();
    q_hold = bus.q;
    drive(4'b0001, 4'b0000);
    aborts = 0;
    for (int s = 0; s < LM; s++) begin
      #1;
      chk("wd_ready0", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      m_edge(exp_ready());
      #1;
      if (bus.lock_abort) aborts++;
      chk("wd_q_hold", bus.q, q_hold);
      @(negedge clk);
    end
    chk("wd_abort_pulse", 32'(bus.lock_abort), 32'd1);
    chk("wd_busy_fall", 32'(bus.busy), 32'd0);
    step();
    if (bus.lock_abort) aborts++;
    chk("wd_abort_once", 32'(aborts), 32'd1);
    chk("wd_next_owner", 32'(bus.q_owner), 32'd0);

    // collision at expiry, owner releases / owner keeps lock
    for (int pass = 0; pass < 2; pass++) begin
      drive(4'b0100, 4'b0100);
      step();
      drive(4'b0000, 4'b0000);
      for (int s = 0; s < LM - 1; s++) step();
      tv_data[2] = 32'hC0DE_0000 + 32'(pass);
      drive(4'b0100, pass ? 4'b0100 : 4'b0000);
      step();
      chk("coll_q", bus.q, 32'hC0DE_0000 + 32'(pass));
      chk("coll_abort", 32'(bus.lock_abort), 32'd0);
      chk("coll_busy", 32'(bus.busy), 32'(pass));
      if (pass == 1) begin
        drive(4'b0100, 4'b0000);
        step();
      end
    end

    // mid-burst reset while LOCKED(3)
    drive(4'b1000, 4'b1000);
    step();
    chk("mb_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mb_rst_q", bus.q, 32'h0);
    chk("mb_rst_busy", 32'(bus.busy), 32'd0);
    chk("mb_rst_q_valid", 32'(bus.q_valid), 32'd0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1001, 4'b0000);
    step();
    chk("mb_first_owner", 32'(bus.q_owner), 32'd0);

    // random traffic
    for (int s = 0; s < 600; s++) begin
      tv_valid = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      tv_lock  = N'($urandom);
      for (int i = 0; i < N; i++) tv_data[i] = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
